approx_error_monitor: RTL and testbench



---
 rtl/approx_error_monitor.sv | 158 +++++++++++++++
 tb/tb_approx_error_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_error_monitor.sv
// Error-statistics stage for an approximate multiplier: recomputes the exact product and
// accumulates count, error count, saturating error sum and (with APPROX_MON_MAX_EN) max error.
module approx_error_monitor #(
   parameter int WIDTH       = 16,
   parameter int NUM_SAMPLES = 1024,
   parameter int CNT_W       = 32,
   parameter int ACC_W       = 48
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   input  logic [2*WIDTH:0]   approx_prod,
   output logic [CNT_W-1:0]   sample_count,
   output logic [CNT_W-1:0]   err_count,
   output logic [ACC_W-1:0]   err_sum,
   output logic [2*WIDTH:0]   err_max,
   output logic               done
);

   localparam int PW    = 2*WIDTH + 1;
   localparam int SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);
   localparam logic [CNT_W-1:0] BATCH    = CNT_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [ACC_W-1:0] ACC_MAX  = '1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   accepted;
   logic               accept;
   logic               last_accept;
   logic               pipe_empty;

   logic               s1_valid;
   logic [WIDTH-1:0]   s1_in1;
   logic [WIDTH-1:0]   s1_in2;
   logic [PW-1:0]      s1_approx;
   logic               s2_valid;
   logic [PW-1:0]      s2_ed;

   logic [2*WIDTH-1:0] s1_exact;
   logic [PW-1:0]      exact_ext;
   logic [PW-1:0]      ed;
   logic [SUM_W-1:0]   sum_wide;
   logic [ACC_W-1:0]   sum_next;

   // A sample presented in the same cycle as start is dropped.
   assign accept      = in_valid && in_ready && !start;
   assign last_accept = accept && (accepted == LAST_IDX);
   assign pipe_empty  = !s1_valid && !s2_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (start) begin
         state_next = RUN;
      end else begin
         case (state)
            RUN:     if (last_accept) state_next = DRAIN;
            DRAIN:   if (pipe_empty)  state_next = DONE;
            default: state_next = state;
         endcase
      end
   end

   always_comb begin
      in_ready = (state == RUN) && (accepted < BATCH);
      done     = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accepted <= '0;
      end else if (start) begin
         accepted <= '0;
      end else if (accept) begin
         accepted <= accepted + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_in1    <= '0;
         s1_in2    <= '0;
         s1_approx <= '0;
         s2_valid  <= 1'b0;
         s2_ed     <= '0;
      end else if (start) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_in1    <= in1;
            s1_in2    <= in2;
            s1_approx <= approx_prod;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_ed <= ed;
         end
      end
   end

   // Sum is formed one bit wider than either operand so overflow is visible for saturation.
   always_comb begin
      s1_exact  = (2*WIDTH)'(s1_in1) * (2*WIDTH)'(s1_in2);
      exact_ext = {1'b0, s1_exact};
      ed        = (s1_approx >= exact_ext) ? (s1_approx - exact_ext) : (exact_ext - s1_approx);
      sum_wide  = SUM_W'(err_sum) + SUM_W'(s2_ed);
      sum_next  = (sum_wide > SUM_W'(ACC_MAX)) ? ACC_MAX : sum_wide[ACC_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_count <= '0;
         err_count    <= '0;
         err_sum      <= '0;
      end else if (start) begin
         sample_count <= '0;
         err_count    <= '0;
         err_sum      <= '0;
      end else if (s2_valid) begin
         if (sample_count != CNT_MAX) sample_count <= sample_count + CNT_W'(1);
         if ((s2_ed != '0) && (err_count != CNT_MAX)) err_count <= err_count + CNT_W'(1);
         err_sum <= sum_next;
      end
   end

`ifdef APPROX_MON_MAX_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_max <= '0;
      end else if (start) begin
         err_max <= '0;
      end else if (s2_valid && (s2_ed > err_max)) begin
         err_max <= s2_ed;
      end
   end
`else
   assign err_max = '0;
`endif

endmodule

// File: tb/tb_approx_error_monitor.sv
// Testbench for approx_error_monitor: randomized batches checked against a plain-arithmetic model.
module tb_approx_error_monitor;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int CW = 32;
   localparam int AW = 33;
   localparam int PW = 2*W + 1;
   localparam longint unsigned SUM_MAX = (64'd1 << AW) - 64'd1;
`ifdef APPROX_MON_MAX_EN
   localparam bit MAX_EN = 1'b1;
`else
   localparam bit MAX_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in1 = '0;
   logic [W-1:0]  in2 = '0;
   logic [PW-1:0] approx_prod = '0;
   logic [CW-1:0] sample_count;
   logic [CW-1:0] err_count;
   logic [AW-1:0] err_sum;
   logic [PW-1:0] err_max;
   logic          done;

   int checks = 0;
   int failures = 0;

   longint unsigned m_count, m_err, m_sum, m_max;
   logic [W-1:0]  va [N];
   logic [W-1:0]  vb [N];
   logic [PW-1:0] vp [N];
   int            ready_miss;
   int            done_edges;
   logic          ready_after;

   approx_error_monitor #(.WIDTH(W), .NUM_SAMPLES(N), .CNT_W(CW), .ACC_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .approx_prod(approx_prod), .sample_count(sample_count),
      .err_count(err_count), .err_sum(err_sum), .err_max(err_max), .done(done)
   );

   always #5 clk = ~clk;

   function automatic longint unsigned exp_max();
      return MAX_EN ? m_max : 64'd0;
   endfunction

   function automatic void model_clear();
      m_count = 0; m_err = 0; m_sum = 0; m_max = 0;
   endfunction

   function automatic void model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] p);
      longint unsigned exact, approx, ed;
      exact  = 64'(a) * 64'(b);
      approx = 64'(p);
      ed     = (approx >= exact) ? approx - exact : exact - approx;
      m_count++;
      if (ed != 0) m_err++;
      m_sum = (m_sum + ed > SUM_MAX) ? SUM_MAX : m_sum + ed;
      if (ed > m_max) m_max = ed;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      model_clear();
   endtask

   // Fill the batch arrays: 0 exact, 1 exact+5, 2 mixed above/below/random.
   task automatic fill_random(input int mode);
      longint unsigned exact;
      for (int i = 0; i < N; i++) begin
         va[i] = W'($urandom_range(64, 16'hFFFF));
         vb[i] = W'($urandom_range(64, 16'hFFFF));
         exact = 64'(va[i]) * 64'(vb[i]);
         case (mode)
            0: vp[i] = PW'(exact);
            1: vp[i] = PW'(exact + 5);
            default: begin
               case ($urandom_range(0, 3))
                  0: vp[i] = PW'(exact);
                  1: vp[i] = PW'(exact + 64'($urandom_range(1, 1000)));
                  2: vp[i] = PW'(exact - 64'($urandom_range(1, 1000)));
                  default: vp[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
               endcase
            end
         endcase
      end
   endtask

   // Present the batch with in_valid held high, then optionally count edges until done.
   task automatic drive_batch(input bit wait_done);
      ready_miss = 0;
      for (int i = 0; i < N; i++) begin
         in1 = va[i]; in2 = vb[i]; approx_prod = vp[i]; in_valid = 1'b1;
         if (in_ready !== 1'b1) ready_miss++;
         model_add(va[i], vb[i], vp[i]);
         tick();
      end
      in_valid = 1'b0;
      ready_after = in_ready;
      done_edges = 0;
      if (wait_done) begin
         while (done !== 1'b1 && done_edges < 20) begin
            tick();
            done_edges++;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      in_valid = 1'b1;
      repeat (2) tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset.in_ready got %b expected 0", in_ready); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset.done got %b expected 0", done); end
      checks++; if (sample_count !== '0 || err_count !== '0) begin failures++; $display("[TB] FAIL reset.counts got %0d/%0d expected 0/0", sample_count, err_count); end
      checks++; if (err_sum !== '0 || err_max !== '0) begin failures++; $display("[TB] FAIL reset.err got sum %0h max %0h expected 0/0", err_sum, err_max); end
      rst = 1'b0;
      repeat (2) tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL idle.in_ready got %b expected 0", in_ready); end
      in_valid = 1'b0;
   endtask

   task automatic test_exact_batch();
      do_start();
      fill_random(0);
      drive_batch(1'b1);
      checks++; if (ready_miss != 0) begin failures++; $display("[TB] FAIL exact.throughput got %0d stalls expected 0", ready_miss); end
      checks++; if (done_edges != 3) begin failures++; $display("[TB] FAIL exact.done_latency got %0d expected 3", done_edges); end
      checks++; if (sample_count !== CW'(m_count)) begin failures++; $display("[TB] FAIL exact.sample_count got %0d expected %0d", sample_count, m_count); end
      checks++; if (err_count !== CW'(m_err)) begin failures++; $display("[TB] FAIL exact.err_count got %0d expected %0d", err_count, m_err); end
      checks++; if (err_sum !== AW'(m_sum)) begin failures++; $display("[TB] FAIL exact.err_sum got %0h expected %0h", err_sum, m_sum); end
      checks++; if (err_max !== PW'(exp_max())) begin failures++; $display("[TB] FAIL exact.err_max got %0h expected %0h", err_max, exp_max()); end
      in1 = 16'h1234; in2 = 16'h0042; approx_prod = '1; in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL done_hold.flags got done %b ready %b expected 1/0", done, in_ready); end
      checks++; if (sample_count !== CW'(N) || err_sum !== AW'(m_sum)) begin failures++; $display("[TB] FAIL done_hold.stats got %0d/%0h expected %0d/%0h", sample_count, err_sum, N, m_sum); end
   endtask

   task automatic test_offset_batch();
      do_start();
      fill_random(1);
      drive_batch(1'b1);
      checks++; if (ready_miss != 0) begin failures++; $display("[TB] FAIL offset.throughput got %0d stalls expected 0", ready_miss); end
      checks++; if (ready_after !== 1'b0) begin failures++; $display("[TB] FAIL offset.ready_after_last got %b expected 0", ready_after); end
      checks++; if (done_edges != 3) begin failures++; $display("[TB] FAIL offset.done_latency got %0d expected 3", done_edges); end
      checks++; if (err_count !== CW'(m_err)) begin failures++; $display("[TB] FAIL offset.err_count got %0d expected %0d", err_count, m_err); end
      checks++; if (err_sum !== AW'(m_sum)) begin failures++; $display("[TB] FAIL offset.err_sum got %0d expected %0d", err_sum, m_sum); end
      checks++; if (err_max !== PW'(exp_max())) begin failures++; $display("[TB] FAIL offset.err_max got %0d expected %0d", err_max, exp_max()); end
   endtask

   task automatic test_latency();
      do_start();
      in1 = 16'd3; in2 = 16'd2; approx_prod = PW'(3); in_valid = 1'b1;
      model_add(16'd3, 16'd2, PW'(3));
      tick();
      in_valid = 1'b0;
      checks++; if (sample_count !== '0) begin failures++; $display("[TB] FAIL latency.edge1 got %0d expected 0", sample_count); end
      tick();
      checks++; if (sample_count !== '0) begin failures++; $display("[TB] FAIL latency.edge2 got %0d expected 0", sample_count); end
      tick();
      checks++; if (sample_count !== CW'(m_count) || err_sum !== AW'(m_sum)) begin failures++; $display("[TB] FAIL latency.edge3 got %0d/%0d expected %0d/%0d", sample_count, err_sum, m_count, m_sum); end
      checks++; if (err_count !== CW'(m_err)) begin failures++; $display("[TB] FAIL latency.below_exact got %0d expected %0d", err_count, m_err); end
   endtask

   task automatic test_random_batches();
      for (int b = 0; b < 4; b++) begin
         do_start();
         fill_random(2);
         drive_batch(1'b1);
         checks++; if (done_edges != 3) begin failures++; $display("[TB] FAIL random%0d.done_latency got %0d expected 3", b, done_edges); end
         checks++; if (err_count !== CW'(m_err)) begin failures++; $display("[TB] FAIL random%0d.err_count got %0d expected %0d", b, err_count, m_err); end
         checks++; if (err_sum !== AW'(m_sum)) begin failures++; $display("[TB] FAIL random%0d.err_sum got %0h expected %0h", b, err_sum, m_sum); end
         checks++; if (err_max !== PW'(exp_max())) begin failures++; $display("[TB] FAIL random%0d.err_max got %0h expected %0h", b, err_max, exp_max()); end
      end
   endtask

   task automatic test_max_saturation();
      do_start();
      va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vp[0] = '0;
      va[1] = 16'h0000; vb[1] = 16'h1234; vp[1] = '1;
      va[2] = 16'd7;    vb[2] = 16'd9;    vp[2] = PW'(63);
      va[3] = 16'hFFFF; vb[3] = 16'hFFFF; vp[3] = '0;
      drive_batch(1'b1);
      checks++; if (err_sum !== {AW{1'b1}}) begin failures++; $display("[TB] FAIL sat.err_sum got %0h expected %0h", err_sum, SUM_MAX); end
      checks++; if (err_sum !== AW'(m_sum)) begin failures++; $display("[TB] FAIL sat.model_sum got %0h expected %0h", err_sum, m_sum); end
      checks++; if (err_count !== CW'(3)) begin failures++; $display("[TB] FAIL sat.err_count got %0d expected 3", err_count); end
      checks++; if (err_max !== PW'(exp_max())) begin failures++; $display("[TB] FAIL sat.err_max got %0h expected %0h", err_max, exp_max()); end
      do_start();
      in1 = 16'hFFFF; in2 = 16'hFFFF; approx_prod = '0; in_valid = 1'b1;
      model_add(16'hFFFF, 16'hFFFF, '0);
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      checks++; if (err_sum !== AW'(33'h0FFFE0001)) begin failures++; $display("[TB] FAIL full_scale.err_sum got %0h expected fffe0001", err_sum); end
      checks++; if (err_max !== PW'(exp_max())) begin failures++; $display("[TB] FAIL full_scale.err_max got %0h expected %0h", err_max, exp_max()); end
   endtask

   task automatic test_reset_midrun();
      do_start();
      fill_random(1);
      for (int i = 0; i < 3; i++) begin
         in1 = va[i]; in2 = vb[i]; approx_prod = vp[i]; in_valid = 1'b1;
         tick();
      end
      checks++; if (sample_count !== CW'(1)) begin failures++; $display("[TB] FAIL midrun.pre_reset got %0d expected 1", sample_count); end
      #2 rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL midrun.async_flags got ready %b done %b expected 0/0", in_ready, done); end
      checks++; if (sample_count !== '0 || err_count !== '0 || err_sum !== '0 || err_max !== '0) begin failures++; $display("[TB] FAIL midrun.async_stats got %0d/%0d/%0h/%0h expected 0", sample_count, err_count, err_sum, err_max); end
      tick();
      #2 rst = 1'b0;
      repeat (4) tick();
      in_valid = 1'b0;
      checks++; if (sample_count !== '0 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrun.in_flight got count %0d ready %b expected 0/0", sample_count, in_ready); end
      model_clear();
   endtask

   task automatic test_restart_in_drain();
      do_start();
      fill_random(1);
      drive_batch(1'b0);
      start = 1'b1; in1 = 16'h00FF; in2 = 16'h00FF; approx_prod = '1; in_valid = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b0;
      model_clear();
      checks++; if (sample_count !== '0 || err_sum !== '0) begin failures++; $display("[TB] FAIL restart.cleared got %0d/%0h expected 0/0", sample_count, err_sum); end
      checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("[TB] FAIL restart.state got ready %b done %b expected 1/0", in_ready, done); end
      repeat (3) tick();
      checks++; if (sample_count !== '0) begin failures++; $display("[TB] FAIL restart.flushed got %0d expected 0", sample_count); end
      fill_random(2);
      drive_batch(1'b1);
      checks++; if (sample_count !== CW'(N)) begin failures++; $display("[TB] FAIL restart.batch_count got %0d expected %0d", sample_count, N); end
      checks++; if (done_edges != 3) begin failures++; $display("[TB] FAIL restart.done_latency got %0d expected 3", done_edges); end
      checks++; if (err_sum !== AW'(m_sum) || err_count !== CW'(m_err)) begin failures++; $display("[TB] FAIL restart.stats got %0h/%0d expected %0h/%0d", err_sum, err_count, m_sum, m_err); end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_exact_batch();
      test_offset_batch();
      test_latency();
      test_random_batches();
      test_max_saturation();
      test_reset_midrun();
      test_restart_in_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
